turbosound_ctrl: RTL and testbench

//  Bus-side controller for N AY/YM2149 PSGs on a ZX Spectrum 128 bus (TurboSound-N successor to dual-PSG glue).

---
 rtl/turbosound_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_turbosound_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbosound_ctrl.sv
// TurboSound-N bus controller: Z80 port decode, software PSG chip select,
// per-chip registered BC1/BDIR with BDIR stretch, #FE beeper/tape latch and
// a turbo-compensated PSG master clock divider.
module turbosound_ctrl #(
  parameter int NUM_CHIPS = 2,
  parameter int SEL_BITS  = 2,
  parameter int CLK_DIV   = 2,
  parameter int BDIR_HOLD = 1
) (
  input  logic                 cpu_clock,
  input  logic                 reset,
  input  logic                 turbo,
  input  logic                 a0,
  input  logic                 a1,
  input  logic                 a14,
  input  logic                 a15,
  input  logic                 iorq,
  input  logic                 rd,
  input  logic                 wr,
  input  logic                 m1,
  input  logic                 dos,
  input  logic [7:0]           d,
  output logic [NUM_CHIPS-1:0] bc1,
  output logic [NUM_CHIPS-1:0] bdir,
  output logic                 ym_clock,
  output logic                 ioge_c,
  output logic                 beeper,
  output logic                 tapeout,
  output logic [SEL_BITS-1:0]  chip_sel
);

  localparam int DIV_W = $clog2(2 * CLK_DIV) + 1;
  localparam logic [SEL_BITS:0] NUM_CHIPS_W = (SEL_BITS + 1)'(NUM_CHIPS);

  logic s_a0, s_a1, s_a14, s_a15, s_iorq, s_rd, s_wr, s_m1, s_dos;
  logic [7:0] s_d;

  logic io, psg, reg_wr, reg_rd, dat_wr, fe_wr;
  logic sel_byte, sel_wr, acc_wr, acc_rd;
  logic [SEL_BITS-1:0] sel_idx;
  logic reg_wr_q, fe_wr_q, acc_wr_q;

  logic [NUM_CHIPS-1:0] chip_mask, bdir_n, bc1_n;
  logic [2:0] hold_cnt, hold_n;

  logic [DIV_W-1:0] ym_cnt, ym_tc;
  logic turbo_mode;

  // Sample the Z80 bus once per clock; strobes reset to their idle (high) level
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      s_a0   <= 1'b0;
      s_a1   <= 1'b0;
      s_a14  <= 1'b0;
      s_a15  <= 1'b0;
      s_iorq <= 1'b1;
      s_rd   <= 1'b1;
      s_wr   <= 1'b1;
      s_m1   <= 1'b1;
      s_dos  <= 1'b0;
      s_d    <= 8'h00;
    end else begin
      s_a0   <= a0;
      s_a1   <= a1;
      s_a14  <= a14;
      s_a15  <= a15;
      s_iorq <= iorq;
      s_rd   <= rd;
      s_wr   <= wr;
      s_m1   <= m1;
      s_dos  <= dos;
      s_d    <= d;
    end
  end

  assign io      = !s_iorq && s_m1;
  assign psg     = io && s_a15 && s_a0 && !s_a1 && s_dos;
  assign reg_wr  = psg && s_a14 && !s_wr;
  assign reg_rd  = psg && s_a14 && !s_rd;
  assign dat_wr  = psg && !s_a14 && !s_wr;
  assign fe_wr   = io && !s_a0 && !s_wr;

  // A select byte has all upper bits set and an inverted index naming a fitted chip
  assign sel_idx  = ~s_d[SEL_BITS-1:0];
  assign sel_byte = (&s_d[7:SEL_BITS]) && ({1'b0, sel_idx} < NUM_CHIPS_W);
  assign sel_wr   = reg_wr && sel_byte;
  assign acc_wr   = (reg_wr && !sel_byte) || dat_wr;
  assign acc_rd   = reg_rd && s_wr;

  // One-hot mask of the currently selected chip
  always_comb begin
    chip_mask = '0;
    for (int i = 0; i < NUM_CHIPS; i++) begin
      chip_mask[i] = (chip_sel == SEL_BITS'(i));
    end
  end

  // Next BC1/BDIR: live access code, otherwise stretch the last write, otherwise idle
  always_comb begin
    bdir_n = bdir;
    bc1_n  = bc1;
    hold_n = hold_cnt;
    if (acc_wr) begin
      bdir_n = chip_mask;
      bc1_n  = reg_wr ? chip_mask : '0;
      hold_n = 3'd0;
    end else if (acc_rd) begin
      bdir_n = '0;
      bc1_n  = chip_mask;
      hold_n = 3'd0;
    end else if (acc_wr_q) begin
      hold_n = 3'(BDIR_HOLD);
      if (BDIR_HOLD == 0) begin
        bdir_n = '0;
        bc1_n  = '0;
      end
    end else if (hold_cnt != 3'd0) begin
      hold_n = hold_cnt - 3'd1;
      if (hold_cnt == 3'd1) begin
        bdir_n = '0;
        bc1_n  = '0;
      end
    end else begin
      bdir_n = '0;
      bc1_n  = '0;
    end
  end

  // Register PSG bus outputs, hold counter and the strobe-history flags
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      bdir     <= '0;
      bc1      <= '0;
      hold_cnt <= 3'd0;
      ioge_c   <= 1'b0;
      acc_wr_q <= 1'b0;
      reg_wr_q <= 1'b0;
      fe_wr_q  <= 1'b0;
    end else begin
      bdir     <= bdir_n;
      bc1      <= bc1_n;
      hold_cnt <= hold_n;
      ioge_c   <= reg_rd;
      acc_wr_q <= acc_wr;
      reg_wr_q <= reg_wr;
      fe_wr_q  <= fe_wr;
    end
  end

  // Chip select latches on the first sampled cycle of a select write
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      chip_sel <= '0;
    end else if (sel_wr && !reg_wr_q) begin
      chip_sel <= sel_idx;
    end
  end

  // Beeper and tape output latch on the leading edge of a #FE write
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      beeper  <= 1'b0;
      tapeout <= 1'b0;
    end else if (fe_wr && !fe_wr_q) begin
      beeper  <= s_d[4];
      tapeout <= s_d[3];
    end
  end

  assign ym_tc = turbo_mode ? DIV_W'(2 * CLK_DIV - 1) : DIV_W'(CLK_DIV - 1);

  // PSG clock divider; turbo is only adopted at terminal count so half-periods never shorten
  always_ff @(posedge cpu_clock or negedge reset) begin
    if (!reset) begin
      ym_cnt     <= '0;
      ym_clock   <= 1'b0;
      turbo_mode <= 1'b0;
    end else if (ym_cnt == ym_tc) begin
      ym_cnt     <= '0;
      ym_clock   <= ~ym_clock;
      turbo_mode <= turbo;
    end else begin
      ym_cnt     <= ym_cnt + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_turbosound_ctrl.sv
// Scoreboard bench for turbosound_ctrl: bus transactions push expected PSG
// bursts, chip-select changes and beeper/tape changes into queues; a monitor
// pops and compares whenever the DUT outputs change. PSG clock half-periods
// are checked against the turbo level seen at each toggle.
`timescale 1ns/1ps
module tb_turbosound_ctrl;

  localparam int NUM_CHIPS = 2;
  localparam int SEL_BITS  = 2;
  localparam int CLK_DIV   = 2;
  localparam int BDIR_HOLD = 1;

  logic cpu_clock = 1'b0;
  logic reset = 1'b0;
  logic turbo = 1'b0;
  logic a0 = 1'b1, a1 = 1'b1, a14 = 1'b1, a15 = 1'b1;
  logic iorq = 1'b1, rd = 1'b1, wr = 1'b1, m1 = 1'b1, dos = 1'b1;
  logic [7:0] d = 8'h00;
  logic [NUM_CHIPS-1:0] bc1, bdir;
  logic ym_clock, ioge_c, beeper, tapeout;
  logic [SEL_BITS-1:0] chip_sel;

  turbosound_ctrl #(
    .NUM_CHIPS(NUM_CHIPS),
    .SEL_BITS (SEL_BITS),
    .CLK_DIV  (CLK_DIV),
    .BDIR_HOLD(BDIR_HOLD)
  ) dut (
    .cpu_clock(cpu_clock),
    .reset    (reset),
    .turbo    (turbo),
    .a0       (a0),
    .a1       (a1),
    .a14      (a14),
    .a15      (a15),
    .iorq     (iorq),
    .rd       (rd),
    .wr       (wr),
    .m1       (m1),
    .dos      (dos),
    .d        (d),
    .bc1      (bc1),
    .bdir     (bdir),
    .ym_clock (ym_clock),
    .ioge_c   (ioge_c),
    .beeper   (beeper),
    .tapeout  (tapeout),
    .chip_sel (chip_sel)
  );

  always #5 cpu_clock = ~cpu_clock;

  typedef struct {
    int                   start;
    int                   len;
    logic [NUM_CHIPS-1:0] bdir;
    logic [NUM_CHIPS-1:0] bc1;
    logic                 ioge;
  } burst_t;

  typedef struct {
    int                  cyc;
    logic [SEL_BITS-1:0] val;
  } sel_t;

  typedef struct {
    int   cyc;
    logic beep;
    logic tape;
  } fe_t;

  burst_t burst_q[$];
  sel_t   sel_q[$];
  fe_t    fe_q[$];

  int asserts = 0;
  int fails = 0;
  int cyc = 0;
  logic turbo_at_edge = 1'b0;
  bit done = 1'b0;

  logic [SEL_BITS-1:0] model_sel = '0;
  logic model_beep = 1'b0;
  logic model_tape = 1'b0;

  // Edge counter and the turbo level seen by the DUT at each rising edge
  always @(posedge cpu_clock) begin
    cyc <= cyc + 1;
    turbo_at_edge <= turbo;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    asserts++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    end
  endtask

  // One Z80 I/O cycle: work out the expected effect from the port rules, then drive it
  task automatic applyStimulus(input logic [15:0] port, input logic [7:0] data, input bit is_wr,
                               input int len, input int gap);
    int c0;
    bit io_ok, psg, fe;
    logic [SEL_BITS-1:0] idx;
    logic [NUM_CHIPS-1:0] mask;
    c0    = cyc;
    io_ok = m1;
    psg   = io_ok && dos && port[15] && port[0] && !port[1];
    fe    = io_ok && !port[0];
    mask  = '0;
    mask[model_sel] = 1'b1;
    if (psg && port[14] && is_wr) begin
      idx = ~data[SEL_BITS-1:0];
      if ((data >> SEL_BITS) == (8'hFF >> SEL_BITS) && int'(idx) < NUM_CHIPS) begin
        if (idx != model_sel) sel_q.push_back('{c0 + 2, idx});
        model_sel = idx;
      end else begin
        burst_q.push_back('{c0 + 2, len + BDIR_HOLD, mask, mask, 1'b0});
      end
    end else if (psg && !port[14] && is_wr) begin
      burst_q.push_back('{c0 + 2, len + BDIR_HOLD, mask, '0, 1'b0});
    end else if (psg && port[14] && !is_wr) begin
      burst_q.push_back('{c0 + 2, len, '0, mask, 1'b1});
    end
    if (fe && is_wr) begin
      if (data[4] != model_beep || data[3] != model_tape)
        fe_q.push_back('{c0 + 2, data[4], data[3]});
      model_beep = data[4];
      model_tape = data[3];
    end
    a0 = port[0]; a1 = port[1]; a14 = port[14]; a15 = port[15];
    d = data;
    iorq = 1'b0;
    if (is_wr) wr = 1'b0;
    else rd = 1'b0;
    repeat (len) @(negedge cpu_clock);
    iorq = 1'b1; wr = 1'b1; rd = 1'b1;
    repeat (gap) @(negedge cpu_clock);
  endtask

  logic [2*NUM_CHIPS:0] prev_val = '0;
  int burst_start = 0;
  logic [SEL_BITS-1:0] prev_sel = '0;
  logic prev_beep = 1'b0, prev_tape = 1'b0, prev_ym = 1'b0;
  int last_toggle = 0;
  int exp_half = CLK_DIV;

  // Monitor: compare each completed output burst / state change against the queues
  always @(negedge cpu_clock) begin : monitor
    logic [2*NUM_CHIPS:0] cur;
    burst_t eb;
    sel_t es;
    fe_t ef;
    if (!reset) begin
      prev_val    = '0;
      prev_sel    = '0;
      prev_beep   = 1'b0;
      prev_tape   = 1'b0;
      prev_ym     = 1'b0;
      last_toggle = cyc;
      exp_half    = CLK_DIV;
    end else begin
      cur = {ioge_c, bdir, bc1};
      if (cur !== prev_val) begin
        if (prev_val != '0) begin
          if (burst_q.size() == 0) begin
            checkOutput("unexpected_burst", 32'(prev_val), 32'd0);
          end else begin
            eb = burst_q.pop_front();
            checkOutput("burst_start", burst_start, eb.start);
            checkOutput("burst_len", cyc - burst_start, eb.len);
            checkOutput("burst_code", 32'(prev_val), 32'({eb.ioge, eb.bdir, eb.bc1}));
          end
        end
        if (cur != '0) burst_start = cyc;
        prev_val = cur;
      end
      if (chip_sel !== prev_sel) begin
        if (sel_q.size() == 0) begin
          checkOutput("unexpected_chip_sel", 32'(chip_sel), 32'(prev_sel));
        end else begin
          es = sel_q.pop_front();
          checkOutput("chip_sel_cycle", cyc, es.cyc);
          checkOutput("chip_sel_value", 32'(chip_sel), 32'(es.val));
        end
        prev_sel = chip_sel;
      end
      if ({beeper, tapeout} !== {prev_beep, prev_tape}) begin
        if (fe_q.size() == 0) begin
          checkOutput("unexpected_fe", 32'({beeper, tapeout}), 32'({prev_beep, prev_tape}));
        end else begin
          ef = fe_q.pop_front();
          checkOutput("fe_cycle", cyc, ef.cyc);
          checkOutput("fe_value", 32'({beeper, tapeout}), 32'({ef.beep, ef.tape}));
        end
        prev_beep = beeper;
        prev_tape = tapeout;
      end
      if (ym_clock !== prev_ym) begin
        checkOutput("ym_half_period", cyc - last_toggle, exp_half);
        last_toggle = cyc;
        exp_half    = turbo_at_edge ? 2 * CLK_DIV : CLK_DIV;
        prev_ym     = ym_clock;
      end else if (cyc - last_toggle > exp_half) begin
        checkOutput("ym_stuck", cyc - last_toggle, exp_half);
        last_toggle = cyc;
      end
    end
  end

  // Turbo is flipped at random moments throughout the run
  initial begin
    @(posedge reset);
    while (!done) begin
      repeat ($urandom_range(5, 40)) @(negedge cpu_clock);
      turbo = ~turbo;
    end
  end

  // Main stimulus: reset, directed scenarios, reset during a strobe, then random traffic
  initial begin
    int c0;
    logic [NUM_CHIPS-1:0] chip0;
    chip0 = '0;
    chip0[0] = 1'b1;

    #50;
    checkOutput("reset_bc1", 32'(bc1), 32'd0);
    checkOutput("reset_bdir", 32'(bdir), 32'd0);
    checkOutput("reset_chip_sel", 32'(chip_sel), 32'd0);
    checkOutput("reset_ioge_c", 32'(ioge_c), 32'd0);
    checkOutput("reset_beeper", 32'({beeper, tapeout}), 32'd0);
    checkOutput("reset_ym_clock", 32'(ym_clock), 32'd0);
    #50;
    @(negedge cpu_clock);
    #2 reset = 1'b1;
    @(negedge cpu_clock);
    repeat (4) @(negedge cpu_clock);

    applyStimulus(16'hFFFD, 8'hFE, 1'b1, 3, 3);
    applyStimulus(16'hFFFD, 8'h07, 1'b1, 2, 3);
    applyStimulus(16'hBFFD, 8'h38, 1'b1, 3, 3);
    applyStimulus(16'hFFFD, 8'hFF, 1'b1, 2, 3);
    applyStimulus(16'hFFFD, 8'h00, 1'b0, 3, 3);
    dos = 1'b0;
    applyStimulus(16'hFFFD, 8'h00, 1'b0, 3, 3);
    applyStimulus(16'hFFFD, 8'hFE, 1'b1, 2, 3);
    dos = 1'b1;
    m1 = 1'b0;
    applyStimulus(16'hBFFD, 8'h12, 1'b1, 2, 3);
    m1 = 1'b1;
    applyStimulus(16'h00FE, 8'h18, 1'b1, 2, 3);
    applyStimulus(16'hFFFD, 8'hFC, 1'b1, 2, 3);
    applyStimulus(16'hFFFD, 8'hFE, 1'b1, 2, 3);

    a0 = 1'b1; a1 = 1'b0; a14 = 1'b0; a15 = 1'b1;
    d = 8'h55; iorq = 1'b0; wr = 1'b0;
    repeat (3) @(negedge cpu_clock);
    #2 reset = 1'b0;
    burst_q.delete();
    sel_q.delete();
    fe_q.delete();
    model_sel  = '0;
    model_beep = 1'b0;
    model_tape = 1'b0;
    #1;
    checkOutput("midreset_bdir", 32'(bdir), 32'd0);
    checkOutput("midreset_bc1", 32'(bc1), 32'd0);
    checkOutput("midreset_chip_sel", 32'(chip_sel), 32'd0);
    checkOutput("midreset_beeper", 32'({beeper, tapeout}), 32'd0);
    @(negedge cpu_clock);
    #2 reset = 1'b1;
    c0 = cyc;
    burst_q.push_back('{c0 + 2, 3 + BDIR_HOLD, chip0, '0, 1'b0});
    repeat (3) @(negedge cpu_clock);
    iorq = 1'b1; wr = 1'b1;
    repeat (BDIR_HOLD + 3) @(negedge cpu_clock);

    for (int i = 0; i < 150; i++) begin
      int k;
      logic [15:0] port;
      logic [7:0] data;
      k = $urandom_range(0, 7);
      case (k)
        0, 1:    port = 16'hFFFD;
        2, 3:    port = 16'hBFFD;
        4:       port = 16'h00FE;
        5:       port = 16'h7FFD;
        6:       port = 16'hFFFF;
        default: port = 16'hFFFC;
      endcase
      data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) data = 8'hFC | 8'($urandom_range(0, 3));
      dos = ($urandom_range(0, 7) != 0);
      m1  = ($urandom_range(0, 7) != 0);
      applyStimulus(port, data, $urandom_range(0, 3) != 0, $urandom_range(1, 4),
                    BDIR_HOLD + 1 + $urandom_range(0, 3));
    end
    dos = 1'b1;
    m1  = 1'b1;

    repeat (20) @(negedge cpu_clock);
    checkOutput("leftover_bursts", burst_q.size(), 0);
    checkOutput("leftover_chip_sel", sel_q.size(), 0);
    checkOutput("leftover_fe", fe_q.size(), 0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
